// File: rtl/input_vector_packer.sv
// Serial-to-parallel packer: gathers NUM_FEAT quantized features into one neuron
// input bus with a single output register plus one spare vector of buffering.
module input_vector_packer #(
  parameter int FEAT_W   = 2,
  parameter int NUM_FEAT = 3,
  parameter int CNT_W    = 16,
  localparam int OUT_W   = FEAT_W * NUM_FEAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_vec,
  output logic              frame_err,
  output logic [CNT_W-1:0]  vec_count
);
  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [OUT_W-1:0]   r_asm;
  logic [OUT_W-1:0]   r_out;
  logic               r_out_valid;
  logic               r_ferr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_acc, w_xfer, w_last_slot, w_final, w_early;
  logic [OUT_W-1:0]   w_asm_upd;

  assign in_ready    = (r_state == FILL) && !rst;
  assign w_acc       = in_valid && in_ready;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_last_slot = (r_idx == LAST_IDX);
  assign w_final     = w_acc && w_last_slot;
  assign w_early     = w_acc && in_last && !w_last_slot;

  assign out_valid = r_out_valid;
  assign out_vec   = r_out;
  assign frame_err = r_ferr;
  assign vec_count = r_cnt;

  // Assembly register with the current beat merged into slot idx.
  always_comb begin
    w_asm_upd = r_asm;
    for (int k = 0; k < NUM_FEAT; k++)
      if (r_idx == IDX_W'(k)) w_asm_upd[k*FEAT_W +: FEAT_W] = in_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: if (w_final && r_out_valid && !out_ready) w_state_nxt = HOLD;
      HOLD: if (out_ready) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_asm       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ferr      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // Error on a short vector, or on a full vector not marked last.
      r_ferr <= w_acc && (in_last != w_last_slot);
      if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc) begin
        r_idx <= (w_last_slot || in_last) ? '0 : r_idx + IDX_W'(1);
        r_asm <= w_early ? '0 : w_asm_upd;
      end
      // The held vector replaces the outgoing one, so out_valid stays high.
      if (r_state == HOLD) begin
        if (out_ready) r_out <= r_asm;
      end else if (w_final && (!r_out_valid || out_ready)) begin
        r_out       <= w_asm_upd;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_input_vector_packer.sv
// Bench for input_vector_packer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_input_vector_packer;
  localparam int FW = 2, NF = 3, OW = FW * NF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic          in_ready, out_valid, frame_err;
  logic [OW-1:0] out_vec;
  logic [15:0]   vec_count;
  logic          in_ready4, out_valid4, frame_err4;
  logic [OW-1:0] out_vec4;
  logic [3:0]    vec_count4;

  int tests = 0, fails = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  input_vector_packer #(.FEAT_W(FW), .NUM_FEAT(NF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .frame_err(frame_err), .vec_count(vec_count));

  input_vector_packer #(.FEAT_W(FW), .NUM_FEAT(NF), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready), .out_vec(out_vec4),
    .frame_err(frame_err4), .vec_count(vec_count4));

  // Reference model: queue of completed vectors not yet consumed (head = out_vec),
  // plus the beats of the vector currently being gathered.
  logic [OW-1:0] mq[$];
  int            beats[$];
  bit            ferr_e;
  logic [15:0]   cnt_e;

  always @(posedge clk) begin
    bit acc, xfer;
    logic [OW-1:0] v;
    if (rst) begin
      mq.delete(); beats.delete(); ferr_e = 0; cnt_e = '0;
    end else begin
      acc  = in_valid && (mq.size() < 2);
      xfer = (mq.size() > 0) && out_ready;
      ferr_e = 0;
      if (xfer) begin void'(mq.pop_front()); cnt_e = cnt_e + 16'd1; end
      if (acc) begin
        beats.push_back(int'(in_data));
        if (beats.size() == NF) begin
          v = '0;
          foreach (beats[k]) v = v | (OW'(beats[k]) << (k * FW));
          mq.push_back(v);
          ferr_e = !in_last;
          beats.delete();
        end else if (in_last) begin
          ferr_e = 1;
          beats.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("m_in_ready", 64'(in_ready), 64'(!rst && mq.size() < 2));
    chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("m_out_vec", 64'(out_vec), 64'(mq[0]));
    chk("m_frame_err", 64'(frame_err), 64'(ferr_e));
    chk("m_vec_count", 64'(vec_count), 64'(cnt_e));
    chk("m_vec_count4", 64'(vec_count4), 64'(cnt_e[3:0]));
  end

  // Drive just after a falling edge, return at the next falling edge (post-posedge).
  task automatic step(input bit v, input int d, input bit l, input bit r);
    #1;
    in_valid = v; in_data = FW'(d); in_last = l; out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_on = 1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_vec", 64'(out_vec), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_vec_count", 64'(vec_count), 64'(0));

    // Basic vector, immediate consume
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 1, 1);
    chk("basic_valid", 64'(out_valid), 64'(1));
    chk("basic_vec", 64'(out_vec), 64'(6'b111001));
    step(0, 0, 0, 1);
    chk("basic_count", 64'(vec_count), 64'(1));

    // Back-pressure fills the spare slot
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 1, 0);
    step(1, 2, 0, 0); step(1, 2, 0, 0); step(1, 2, 1, 0);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_first", 64'(out_vec), 64'(6'b010101));
    step(0, 0, 0, 1);
    chk("bp_second", 64'(out_vec), 64'(6'b101010));
    chk("bp_second_valid", 64'(out_valid), 64'(1));
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    step(0, 0, 0, 1);
    chk("bp_drained", 64'(out_valid), 64'(0));
    chk("bp_count", 64'(vec_count), 64'(3));

    // Short vector
    step(1, 3, 0, 1); step(1, 0, 1, 1);
    chk("short_ferr", 64'(frame_err), 64'(1));
    chk("short_novalid", 64'(out_valid), 64'(0));
    step(1, 1, 0, 1);
    chk("short_ferr_pulse", 64'(frame_err), 64'(0));
    step(1, 1, 0, 1); step(1, 1, 1, 1);
    chk("short_next_vec", 64'(out_vec), 64'(6'b010101));
    step(0, 0, 0, 1);

    // Full vector missing in_last
    step(1, 2, 0, 1); step(1, 2, 0, 1); step(1, 2, 0, 1);
    chk("nolast_vec", 64'(out_vec), 64'(6'b101010));
    chk("nolast_valid", 64'(out_valid), 64'(1));
    chk("nolast_ferr", 64'(frame_err), 64'(1));
    step(0, 0, 0, 1);

    // Reset mid-vector
    step(1, 1, 0, 1); step(1, 2, 0, 1);
    do_reset();
    step(1, 3, 0, 1); step(1, 3, 0, 1); step(1, 3, 1, 1);
    chk("midrst_vec", 64'(out_vec), 64'(6'b111111));
    step(0, 0, 0, 1);
    chk("midrst_count", 64'(vec_count), 64'(1));
    chk("midrst_empty", 64'(out_valid), 64'(0));

    // 4-bit counter wrap
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      step(1, n, 0, 1); step(1, n + 1, 0, 1); step(1, n + 2, 1, 1);
      step(0, 0, 0, 1);
      if (n == 16) chk("wrap_16", 64'(vec_count4), 64'(0));
      if (n == 17) chk("wrap_17", 64'(vec_count4), 64'(1));
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, l, r;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (beats.size() == NF - 1) l = ($urandom_range(0, 9) != 0);
      else                        l = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) #1 rst = 1'b1;
      else                             #1 rst = 1'b0;
      step(v, int'($urandom_range(0, 3)), l, r);
    end
    #1 rst = 1'b0;
    step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_vector_packer.md
INPUT_VECTOR_PACKER -- requirements
Module: input_vector_packer

Interface
REQ-001 SHALL have parameter FEAT_W, default 2, bit width of one quantized input feature.
REQ-002 SHALL have parameter NUM_FEAT, default 3, number of features per layer-input vector (NUM_FEAT >= 2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the emitted-vector counter.
REQ-004 SHALL derive OUT_W = FEAT_W*NUM_FEAT, default 6, which is the width of one neuron input bus M0.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream feature beat valid.
REQ-008 in_ready  output  1  packer accepts a beat this cycle.
REQ-009 in_data  input  FEAT_W  quantized feature value.
REQ-010 in_last  input  1  marks the final feature of a vector.
REQ-011 out_valid  output  1  out_vec holds a complete vector.
REQ-012 out_ready  input  1  downstream LUT layer consumes out_vec.
REQ-013 out_vec  output  OUT_W  packed vector, feature k at bits [k*FEAT_W +: FEAT_W].
REQ-014 frame_err  output  1  one-cycle pulse on a framing violation.
REQ-015 vec_count  output  CNT_W  count of vectors consumed downstream.

Function
REQ-016 Beat accept SHALL be in_valid && in_ready; out transfer SHALL be out_valid && out_ready.
REQ-017 The block SHALL hold an assembly register, a slot index idx (0..NUM_FEAT-1), and an output register; state machine FILL / HOLD.
REQ-018 In FILL, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0; in_ready SHALL be 0 while rst is high.
REQ-019 Each accepted beat SHALL write in_data into assembly slot idx and increment idx.
REQ-020 On the accepted beat with idx == NUM_FEAT-1, the vector is complete; idx SHALL return to 0.
REQ-021 If the vector completes and the output register is empty or transferring this cycle, it SHALL load into out_vec with out_valid = 1 on the next cycle (latency 1 from final beat); state stays FILL.
REQ-022 If the vector completes while out_valid = 1 and out_ready = 0, state SHALL go to HOLD with the vector retained in the assembly register.
REQ-023 In HOLD, on an out transfer cycle, the assembly vector SHALL move to out_vec (out_valid stays 1) and state SHALL return to FILL.
REQ-024 out_valid SHALL clear after a transfer only when no new vector loads in that cycle; out_vec SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025 in_last accepted with idx < NUM_FEAT-1 SHALL pulse frame_err, discard the partial vector, reset idx to 0, and emit nothing.
REQ-026 Final beat (idx == NUM_FEAT-1) accepted with in_last = 0 SHALL still emit the vector and pulse frame_err.
REQ-027 frame_err SHALL be registered, high exactly one cycle after the offending beat.
REQ-028 vec_count SHALL increment by 1 per out transfer, wrapping modulo 2^CNT_W.
REQ-029 Vectors SHALL be emitted in arrival order with none dropped or duplicated absent framing errors.

Reset
REQ-030 With rst high at a clock edge: out_valid = 0, out_vec = 0, frame_err = 0, vec_count = 0, idx = 0, state = FILL, assembly register = 0.
REQ-031 Reset mid-vector or mid-HOLD SHALL discard all partial and pending data; nothing from before reset appears on out_vec.

Verification (FEAT_W=2, NUM_FEAT=3 unless noted)
REQ-032 Beats 01,10,11 (last on third), out_ready=1 -> next cycle out_valid=1, out_vec=6'b111001; vec_count=1 after transfer.
REQ-033 out_ready=0, two vectors 01,01,01 then 10,10,10 -> in_ready=0 after the sixth beat; raising out_ready yields 6'b010101 then 6'b101010 on consecutive cycles; in_ready returns 1.
REQ-034 Beats 11 then 00 with in_last on 00 -> frame_err pulse, no out_valid; following 01,01,01(last) -> out_vec=6'b010101.
REQ-035 Beats 10,10,10 with in_last=0 on third -> out_vec=6'b101010 and frame_err pulse together.
REQ-036 Two beats accepted, then rst for one cycle, then 11,11,11(last) -> only out_vec=6'b111111 emitted, vec_count=1.
REQ-037 CNT_W=4, 17 vectors transferred -> vec_count reads 0 after the 16th and 1 after the 17th.
